// File: rtl/mux4_rr_arbiter_if.sv
// Handshake bundle between four requesters, the arbiter and the sink.
// master = requester/sink side, slave = arbiter side.
interface mux4_rr_arbiter_if #(
  parameter int DW = 8
);
  logic [3:0]    req;
  logic [DW-1:0] din0;
  logic [DW-1:0] din1;
  logic [DW-1:0] din2;
  logic [DW-1:0] din3;
  logic          out_ready;
  logic [3:0]    gnt;
  logic [1:0]    sel;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          xfer;

  modport master (
    output req,
    output din0,
    output din1,
    output din2,
    output din3,
    output out_ready,
    input  gnt,
    input  sel,
    input  out_valid,
    input  out_data,
    input  xfer
  );

  modport slave (
    input  req,
    input  din0,
    input  din1,
    input  din2,
    input  din3,
    input  out_ready,
    output gnt,
    output sel,
    output out_valid,
    output out_data,
    output xfer
  );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving a shared 4:1 data mux.
// Each grant is bounded to MAX_BURST beats; one idle cycle per release.
module mux4_rr_arbiter #(
  parameter int DW        = 8,
  parameter int MAX_BURST = 4
) (
  input logic              clk,
  input logic              rst,
  mux4_rr_arbiter_if.slave bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
  localparam logic [7:0] LAST = 8'(MAX_BURST - 1);

  logic [0:0]    state;
  logic [3:0]    gnt_q;
  logic [1:0]    sel_q;
  logic [1:0]    ptr_q;
  logic [7:0]    cnt_q;

  logic          found;
  logic [1:0]    win;
  logic [1:0]    idx;
  logic          busy;
  logic          valid;
  logic          xfer;
  logic          last;
  logic          rel;
  logic [DW-1:0] mux_d;

  // Rotating priority scan starting at ptr
  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    idx   = ptr_q;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Data mux steered by the registered select
  always_comb begin
    mux_d = '0;
    case (sel_q)
      2'd0:    mux_d = bus.din0;
      2'd1:    mux_d = bus.din1;
      2'd2:    mux_d = bus.din2;
      default: mux_d = bus.din3;
    endcase
  end

  // Handshake and release conditions
  always_comb begin
    busy  = (state == BUSY);
    valid = busy && bus.req[sel_q];
    xfer  = valid && bus.out_ready;
    last  = xfer && (cnt_q == LAST);
    rel   = busy && (!bus.req[sel_q] || last);
  end

  assign bus.gnt       = gnt_q;
  assign bus.sel       = sel_q;
  assign bus.out_valid = valid;
  assign bus.out_data  = busy ? mux_d : '0;
  assign bus.xfer      = xfer;

  // Grant FSM, burst counter and priority pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      gnt_q <= '0;
      sel_q <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state <= BUSY;
            gnt_q <= 4'(1) << win;
            sel_q <= win;
            cnt_q <= '0;
          end
        end
        BUSY: begin
          if (rel) begin
            state <= IDLE;
            gnt_q <= '0;
            cnt_q <= '0;
            ptr_q <= sel_q + 2'd1;
          end else if (xfer) begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: begin
          state <= IDLE;
          gnt_q <= '0;
          cnt_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Scoreboard bench for mux4_rr_arbiter.
// Directed phases queue expected beats; a negedge monitor checks them.
module tb_mux4_rr_arbiter;

  logic clk;
  logic rst;

  mux4_rr_arbiter_if #(.DW(8)) bus ();

  mux4_rr_arbiter #(
    .DW(8),
    .MAX_BURST(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  localparam logic [7:0] D0 = 8'h10;
  localparam logic [7:0] D1 = 8'h21;
  localparam logic [7:0] D2 = 8'h32;
  localparam logic [7:0] D3 = 8'h43;

  int n_chk;
  int n_fail;
  logic [9:0] exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] din_of(int i);
    case (i)
      0:       return D0;
      1:       return D1;
      2:       return D2;
      default: return D3;
    endcase
  endfunction

  task automatic push(int s, int n);
    for (int i = 0; i < n; i++)
      exp_q.push_back({2'(s), din_of(s)});
  endtask

  // Monitor: every transfer must match the next queued beat
  always @(negedge clk) begin
    if (bus.xfer) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_xfer", {bus.sel, bus.out_data}, 0);
      end else begin
        chk("beat", {bus.sel, bus.out_data}, exp_q.pop_front());
      end
    end
  end

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst = 1'b1;
    bus.req = 4'b0;
    bus.out_ready = 1'b0;
    bus.din0 = D0;
    bus.din1 = D1;
    bus.din2 = D2;
    bus.din3 = D3;
    #2;
    chk("rst_gnt", bus.gnt, 0);
    chk("rst_sel", bus.sel, 0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_data", bus.out_data, 0);
    chk("rst_xfer", bus.xfer, 0);
    tick();
    rst = 1'b0;

    // single requester 2, full bursts
    bus.req = 4'b0100;
    bus.out_ready = 1'b1;
    tick();
    chk("t2_gnt", bus.gnt, 4'b0100);
    chk("t2_sel", bus.sel, 2);
    push(2, 4);
    repeat (4) tick();
    chk("t2_idle", bus.gnt, 0);
    tick();
    chk("t2_regnt", bus.gnt, 4'b0100);
    chk("t2_resel", bus.sel, 2);
    bus.req = 4'b0;
    tick();

    // reset mid-burst, ptr=3 before reset
    bus.req = 4'b1010;
    tick();
    chk("t1_gnt", bus.gnt, 4'b1000);
    chk("t1_sel", bus.sel, 3);
    push(3, 2);
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("t1_rgnt", bus.gnt, 0);
    chk("t1_rsel", bus.sel, 0);
    chk("t1_rvalid", bus.out_valid, 0);
    chk("t1_rxfer", bus.xfer, 0);
    #1;
    rst = 1'b0;
    tick();
    chk("t1_gnt2", bus.gnt, 4'b0010);
    chk("t1_sel2", bus.sel, 1);
    bus.req = 4'b0;
    tick();
    rst = 1'b1;
    #1;
    rst = 1'b0;

    // all requesting: 0,1,2,3,0
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t3_gnt", bus.gnt, 1 << (k % 4));
      chk("t3_sel", bus.sel, k % 4);
      push(k % 4, 4);
      repeat (4) tick();
      chk("t3_idle", bus.gnt, 0);
    end
    bus.req = 4'b0;

    // backpressure on requester 0
    bus.req = 4'b0001;
    bus.out_ready = 1'b0;
    tick();
    chk("t4_gnt", bus.gnt, 4'b0001);
    chk("t4_sel", bus.sel, 0);
    for (int i = 0; i < 3; i++) begin
      chk("t4_valid", bus.out_valid, 1);
      chk("t4_data", bus.out_data, D0);
      chk("t4_xfer", bus.xfer, 0);
      tick();
    end
    chk("t4_hold", bus.gnt, 4'b0001);
    bus.out_ready = 1'b1;
    push(0, 4);
    repeat (4) tick();
    chk("t4_idle", bus.gnt, 0);

    // withdraw after 2 beats, 0 and 3 pending
    bus.req = 4'b1010;
    tick();
    chk("t5_gnt", bus.gnt, 4'b0010);
    push(1, 2);
    tick();
    tick();
    bus.req = 4'b1001;
    tick();
    chk("t5_idle", bus.gnt, 0);
    bus.out_ready = 1'b0;
    tick();
    chk("t5_gnt3", bus.gnt, 4'b1000);
    chk("t5_sel3", bus.sel, 3);
    bus.req = 4'b0;
    bus.out_ready = 1'b1;
    tick();

    // drop right after the last beat of a burst
    bus.req = 4'b0001;
    tick();
    chk("t6_gnt", bus.gnt, 4'b0001);
    push(0, 4);
    repeat (3) tick();
    #6;
    bus.req = 4'b0;
    tick();
    chk("t6_idle", bus.gnt, 0);
    bus.req = 4'b0001;
    tick();
    chk("t6_regnt", bus.gnt, 4'b0001);
    chk("t6_resel", bus.sel, 0);
    bus.req = 4'b0;
    tick();
    tick();
    chk("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
